// File: rtl/sprite_draw.sv
// sprite_draw: Dxyn / 00E0 framebuffer engine. Fetches sprite bytes from RAM,
// XORs them into a byte-addressed monochrome framebuffer with wrap in both
// axes, and reports the collision flag for VF.
module sprite_draw #(
  parameter int FB_W = 64,
  parameter int FB_H = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        clear,
  input  logic [7:0]  vx_in,
  input  logic [7:0]  vy_in,
  input  logic [3:0]  n_in,
  input  logic [15:0] i_in,
  output logic        mem_rd,
  output logic [11:0] mem_addr,
  input  logic [7:0]  mem_data,
  output logic        fb_rd,
  output logic        fb_we,
  output logic [7:0]  fb_addr,
  input  logic [7:0]  fb_rdata,
  output logic [7:0]  fb_wdata,
  output logic        busy,
  output logic        done,
  output logic [7:0]  collision
);

  localparam int X_W  = $clog2(FB_W);
  localparam int Y_W  = $clog2(FB_H);
  localparam int CB_W = X_W - 3;

  typedef enum logic [2:0] {IDLE, FETCH, RD_L, WR_L, RD_R, WR_R, CLR, DONE} state_t;

  state_t            state;
  logic [X_W-1:0]    x_reg;
  logic [Y_W-1:0]    y_reg;
  logic [3:0]        n_reg;
  logic [3:0]        row_reg;
  logic [11:0]       i_reg;
  logic [7:0]        s_reg;
  logic              coll_reg;

  logic [2:0]        off;
  logic [CB_W-1:0]   cb;
  logic [CB_W-1:0]   cb_r;
  logic [Y_W-1:0]    ty;
  logic [15:0]       shifted;
  logic [7:0]        mask_l;
  logic [7:0]        mask_r;
  logic [7:0]        wr_mask;
  logic              wr_state;
  logic              hit;
  logic              last_row;
  logic [7:0]        addr_l;
  logic [7:0]        addr_r;

  // Coordinate bits above the framebuffer size and address bits above 4K are
  // dropped by the modulo wrap; gathered here so they are visibly discarded.
  logic unused_bits;
  assign unused_bits = ^{vx_in[7:X_W], vy_in[7:Y_W], i_in[15:12]};

  assign off      = x_reg[2:0];
  assign cb       = x_reg[X_W-1:3];
  assign cb_r     = cb + 1'b1;                 // wraps to column byte 0
  assign ty       = y_reg + Y_W'(row_reg);     // wraps to row 0
  // One shift yields both halves: upper byte lands at cb, lower at cb+1.
  assign shifted  = {s_reg, 8'h00} >> off;
  assign mask_l   = shifted[15:8];
  assign mask_r   = shifted[7:0];
  assign addr_l   = 8'({ty, cb});
  assign addr_r   = 8'({ty, cb_r});
  assign last_row = (row_reg + 4'd1 == n_reg);

  assign wr_state = (state == WR_L) || (state == WR_R);
  assign wr_mask  = (state == WR_R) ? mask_r : mask_l;
  assign hit      = |(fb_rdata & wr_mask);
  // Read data only arrives in the write cycle, so write data is formed here.
  assign fb_wdata  = wr_state ? (fb_rdata ^ wr_mask) : 8'h00;
  assign collision = {7'b0, coll_reg};

  // Control FSM; strobes and addresses are registered on entry to each state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      x_reg    <= '0;
      y_reg    <= '0;
      n_reg    <= '0;
      row_reg  <= '0;
      i_reg    <= '0;
      s_reg    <= '0;
      coll_reg <= 1'b0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      fb_rd    <= 1'b0;
      fb_we    <= 1'b0;
      fb_addr  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      mem_rd <= 1'b0;
      fb_rd  <= 1'b0;
      fb_we  <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (clear) begin
            busy     <= 1'b1;
            coll_reg <= 1'b0;
            fb_we    <= 1'b1;
            fb_addr  <= 8'h00;
            state    <= CLR;
          end else if (start) begin
            busy     <= 1'b1;
            coll_reg <= 1'b0;
            x_reg    <= vx_in[X_W-1:0];
            y_reg    <= vy_in[Y_W-1:0];
            n_reg    <= n_in;
            i_reg    <= i_in[11:0];
            row_reg  <= 4'd0;
            if (n_in != 4'd0) begin
              mem_rd   <= 1'b1;
              mem_addr <= i_in[11:0];
              state    <= FETCH;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        FETCH: begin
          fb_rd   <= 1'b1;
          fb_addr <= addr_l;
          state   <= RD_L;
        end
        RD_L: begin
          s_reg <= mem_data;
          fb_we <= 1'b1;
          state <= WR_L;
        end
        RD_R: begin
          fb_we <= 1'b1;
          state <= WR_R;
        end
        WR_L, WR_R: begin
          coll_reg <= coll_reg | hit;
          if (state == WR_L && off != 3'd0) begin
            fb_rd   <= 1'b1;
            fb_addr <= addr_r;
            state   <= RD_R;
          end else if (last_row) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            row_reg  <= row_reg + 4'd1;
            mem_rd   <= 1'b1;
            mem_addr <= i_reg + 12'(row_reg) + 12'd1;
            state    <= FETCH;
          end
        end
        CLR: begin
          if (fb_addr == 8'hFF) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            fb_we   <= 1'b1;
            fb_addr <= fb_addr + 8'd1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_draw.sv
// tb_sprite_draw: directed and random draws against a pixel-level framebuffer
// model, plus clear, priority, busy-ignore and mid-operation reset.
module tb_sprite_draw;

  logic        clk, rst_n, start, clear;
  logic [7:0]  vx_in, vy_in;
  logic [3:0]  n_in;
  logic [15:0] i_in;
  logic        mem_rd;
  logic [11:0] mem_addr;
  logic [7:0]  mem_data;
  logic        fb_rd, fb_we;
  logic [7:0]  fb_addr, fb_rdata, fb_wdata;
  logic        busy, done;
  logic [7:0]  collision;

  logic [7:0] ram    [4096];
  logic [7:0] fb_mem [256];
  logic [7:0] ref_fb [256];

  int errors = 0;
  int checks = 0;
  int mem_rd_cnt = 0, fb_rd_cnt = 0, fb_we_cnt = 0, strobe_viol = 0;

  sprite_draw dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .vx_in(vx_in), .vy_in(vy_in), .n_in(n_in), .i_in(i_in),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .fb_rd(fb_rd), .fb_we(fb_we), .fb_addr(fb_addr),
    .fb_rdata(fb_rdata), .fb_wdata(fb_wdata),
    .busy(busy), .done(done), .collision(collision)
  );

  always #5 clk = ~clk;

  // RAM and framebuffer memories with one-cycle read latency, plus strobe counters
  always @(posedge clk) begin
    if (mem_rd) mem_data <= ram[mem_addr];
    if (fb_rd)  fb_rdata <= fb_mem[fb_addr];
    if (fb_we)  fb_mem[fb_addr] = fb_wdata;
    if (mem_rd) mem_rd_cnt <= mem_rd_cnt + 1;
    if (fb_rd)  fb_rd_cnt  <= fb_rd_cnt + 1;
    if (fb_we)  fb_we_cnt  <= fb_we_cnt + 1;
  end

  // At most one memory strobe per cycle
  always @(negedge clk) begin
    if (int'(mem_rd) + int'(fb_rd) + int'(fb_we) > 1) strobe_viol = strobe_viol + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pixel-level reference: each set sprite bit toggles one pixel with wrap.
  function automatic logic model_draw(input logic [7:0] vx, input logic [7:0] vy,
                                      input logic [3:0] n, input logic [15:0] i);
    logic c;
    c = 1'b0;
    for (int r = 0; r < int'(n); r++) begin
      logic [7:0] s;
      int yy;
      s  = ram[(int'(i) + r) % 4096];
      yy = (int'(vy) % 32 + r) % 32;
      for (int b = 0; b < 8; b++) begin
        if (s[7-b]) begin
          int xx, a, bt;
          xx = (int'(vx) % 64 + b) % 64;
          a  = yy * 8 + xx / 8;
          bt = 7 - xx % 8;
          if (ref_fb[a][bt]) c = 1'b1;
          ref_fb[a][bt] = ~ref_fb[a][bt];
        end
      end
    end
    return c;
  endfunction

  task automatic check_fb(input string tag);
    for (int a = 0; a < 256; a++)
      check($sformatf("%s_fb%0d", tag, a), 32'(fb_mem[a]), 32'(ref_fb[a]));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_coll"}, 32'(collision), 0);
    check({tag, "_mem_rd"}, 32'(mem_rd), 0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 0);
    check({tag, "_fb_rd"}, 32'(fb_rd), 0);
    check({tag, "_fb_we"}, 32'(fb_we), 0);
    check({tag, "_fb_addr"}, 32'(fb_addr), 0);
    check({tag, "_fb_wdata"}, 32'(fb_wdata), 0);
  endtask

  // Count cycles after the accepting edge until done; optionally pulse start while busy.
  task automatic wait_done(output int cyc, input bit pulse);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (pulse && cyc == 2) begin
        start = 1'b1;
        vx_in = vx_in + 8'd3;
        n_in  = 4'd7;
      end else if (pulse && cyc == 3) begin
        start = 1'b0;
      end
    end while (!done && cyc < 600);
  endtask

  task automatic run_draw(input logic [7:0] vx, input logic [7:0] vy, input logic [3:0] n,
                          input logic [15:0] i, input bit pulse, input string tag);
    logic exp_coll;
    int   k, exp_lat, cyc, b_mr, b_fr, b_we, per_row;
    exp_coll = model_draw(vx, vy, n, i);
    per_row  = (vx[2:0] == 3'd0) ? 1 : 2;
    k        = (per_row == 1) ? 3 : 5;
    exp_lat  = 1 + int'(n) * k;
    b_mr = mem_rd_cnt; b_fr = fb_rd_cnt; b_we = fb_we_cnt;
    @(negedge clk);
    vx_in = vx; vy_in = vy; n_in = n; i_in = i; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({tag, "_busy_accept"}, 32'(busy), 1);
    wait_done(cyc, pulse);
    check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_coll"}, 32'(collision), 32'({7'b0, exp_coll}));
    check({tag, "_busy_done"}, 32'(busy), 1);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 0);
    check({tag, "_busy_idle"}, 32'(busy), 0);
    check({tag, "_coll_hold"}, 32'(collision), 32'({7'b0, exp_coll}));
    check({tag, "_mem_rds"}, 32'(mem_rd_cnt - b_mr), 32'(int'(n)));
    check({tag, "_fb_rds"}, 32'(fb_rd_cnt - b_fr), 32'(int'(n) * per_row));
    check({tag, "_fb_wes"}, 32'(fb_we_cnt - b_we), 32'(int'(n) * per_row));
    check_fb(tag);
  endtask

  task automatic run_clear(input bit with_start, input string tag);
    int cyc, b_mr, b_we;
    for (int a = 0; a < 256; a++) ref_fb[a] = 8'h00;
    b_mr = mem_rd_cnt; b_we = fb_we_cnt;
    @(negedge clk);
    clear = 1'b1; start = with_start;
    vx_in = 8'd1; vy_in = 8'd1; n_in = 4'd3; i_in = 16'h0050;
    @(posedge clk);
    #1 clear = 1'b0; start = 1'b0;
    wait_done(cyc, 1'b0);
    check({tag, "_latency"}, 32'(cyc), 257);
    check({tag, "_coll"}, 32'(collision), 0);
    @(negedge clk);
    check({tag, "_busy_idle"}, 32'(busy), 0);
    check({tag, "_fb_wes"}, 32'(fb_we_cnt - b_we), 256);
    check({tag, "_mem_rds"}, 32'(mem_rd_cnt - b_mr), 0);
    check_fb(tag);
  endtask

  initial begin
    int b_mr, b_fr, b_we, cyc;
    clk = 1'b0; rst_n = 1'b1; start = 1'b0; clear = 1'b0;
    vx_in = '0; vy_in = '0; n_in = '0; i_in = '0;
    for (int a = 0; a < 4096; a++) ram[a] = 8'($urandom);
    for (int a = 0; a < 256; a++) begin fb_mem[a] = 8'h00; ref_fb[a] = 8'h00; end

    // Asynchronous reset asserted between edges
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset_async");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    b_mr = mem_rd_cnt; b_fr = fb_rd_cnt; b_we = fb_we_cnt;
    repeat (10) @(negedge clk);
    check("idle_mem_rd", 32'(mem_rd_cnt - b_mr), 0);
    check("idle_fb_rd", 32'(fb_rd_cnt - b_fr), 0);
    check("idle_fb_we", 32'(fb_we_cnt - b_we), 0);
    check("idle_busy", 32'(busy), 0);

    // Aligned "0" glyph
    ram[12'h050] = 8'hF0; ram[12'h051] = 8'h90; ram[12'h052] = 8'h90;
    ram[12'h053] = 8'h90; ram[12'h054] = 8'hF0;
    run_draw(8'd0, 8'd0, 4'd5, 16'h0050, 1'b0, "aligned");
    check("aligned_b0", 32'(fb_mem[0]), 32'h F0);
    check("aligned_b8", 32'(fb_mem[8]), 32'h90);
    check("aligned_b32", 32'(fb_mem[32]), 32'hF0);

    // Redraw erases and collides
    run_draw(8'd0, 8'd0, 4'd5, 16'h0050, 1'b0, "redraw");
    check("redraw_b0", 32'(fb_mem[0]), 0);
    check("redraw_coll", 32'(collision), 1);

    // Horizontal wrap
    ram[12'h100] = 8'hFF;
    run_draw(8'd61, 8'd0, 4'd1, 16'h0100, 1'b0, "hwrap");
    check("hwrap_b7", 32'(fb_mem[7]), 32'h07);
    check("hwrap_b0", 32'(fb_mem[0]), 32'hF8);

    // Vertical wrap and coordinate modulo
    ram[12'h200] = 8'h81; ram[12'h201] = 8'h42;
    run_draw(8'd72, 8'd31, 4'd2, 16'h0200, 1'b0, "vwrap");
    check("vwrap_b249", 32'(fb_mem[249]), 32'h81);
    check("vwrap_b1", 32'(fb_mem[1]), 32'h42);

    // Zero-height sprite and RAM address wrap past 4K
    run_draw(8'd5, 8'd5, 4'd0, 16'h0123, 1'b0, "n0");
    run_draw(8'd3, 8'd10, 4'd4, 16'hFFFE, 1'b0, "iwrap");

    // Random draws
    for (int t = 0; t < 10; t++)
      run_draw(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)), 16'($urandom),
               1'b0, $sformatf("rand%0d", t));

    // start pulsed while busy is ignored
    run_draw(8'd16, 8'd3, 4'd6, 16'h0300, 1'b1, "busy_start");
    repeat (4) begin
      @(negedge clk);
      check("busy_start_no_second", 32'(busy), 0);
    end

    // clear beats start in the same cycle
    run_clear(1'b1, "clear_prio");
    run_draw(8'($urandom), 8'($urandom), 4'd8, 16'($urandom), 1'b0, "post_clear");

    // Reset during row 2 of a draw
    @(negedge clk);
    vx_in = 8'd8; vy_in = 8'd4; n_in = 4'd5; i_in = 16'h0050; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (cyc < 9) begin @(negedge clk); cyc++; end
    check("midrst_busy_before", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    b_we = fb_we_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("midrst_no_we", 32'(fb_we_cnt - b_we), 0);
    check("midrst_busy", 32'(busy), 0);

    run_clear(1'b0, "clear2");
    run_draw(8'd0, 8'd0, 4'd5, 16'h0050, 1'b0, "final");
    check("strobe_exclusive", 32'(strobe_viol), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
